// File: rtl/sp_bram_ctrl_pkg.sv
// Shared types and helpers for the block-RAM request controller.
package sp_bram_ctrl_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } ctrl_state_e;

    // Width of the port tag carried with an in-flight response.
    function automatic int tag_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/sp_bram_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the priority
// pointer, then moves the pointer just past the winner.
module rr_arbiter
    import sp_bram_ctrl_pkg::*;
#(
    parameter  int NUM_PORTS = 2,
    localparam int IdxWidth  = tag_width(NUM_PORTS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 advance,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IdxWidth-1:0]  idx
);

    logic [IdxWidth-1:0] prio_q;
    logic                found;

    function automatic int wrap(input int v);
        return (v >= NUM_PORTS) ? v - NUM_PORTS : v;
    endfunction

    // Cyclic scan starting at the priority pointer; first requester wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && req[wrap(int'(prio_q) + i)]) begin
                found                        = 1'b1;
                gnt[wrap(int'(prio_q) + i)]  = 1'b1;
                idx                          = IdxWidth'(wrap(int'(prio_q) + i));
            end
        end
    end

    // Pointer moves past the winner only when a grant is actually issued.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= '0;
        end else if (advance) begin
            prio_q <= IdxWidth'(wrap(int'(idx) + 1));
        end
    end

endmodule

// File: rtl/sp_bram_ctrl.sv
// Arbiter and sequencer in front of a single-port byte-writable block RAM.
// Optionally zero-fills the RAM after reset, then shares the RAM port among
// requesters round-robin and routes each response back to its issuer.
//
// state | meaning
// CLEAR | writing zero to every word, one per cycle, no grants
// SERVE | arbitrating requesters onto the RAM port
module sp_bram_ctrl
    import sp_bram_ctrl_pkg::*;
#(
    parameter  int NUM_PORTS      = 2,
    parameter  int NB_COL         = 4,
    parameter  int COL_WIDTH      = 8,
    parameter  int RAM_DEPTH      = 1024,
    parameter  bit CLEAR_ON_RESET = 1'b1,
    localparam int DataWidth      = NB_COL * COL_WIDTH,
    localparam int AddrWidth      = $clog2(RAM_DEPTH)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_PORTS-1:0]                req_i,
    input  logic [NUM_PORTS-1:0][AddrWidth-1:0] addr_i,
    input  logic [NUM_PORTS-1:0][DataWidth-1:0] wdata_i,
    input  logic [NUM_PORTS-1:0][NB_COL-1:0]    bwe_i,
    output logic [NUM_PORTS-1:0]                gnt_o,
    output logic [NUM_PORTS-1:0]                rvalid_o,
    output logic [NUM_PORTS-1:0][DataWidth-1:0] rdata_o,
    output logic                                clear_done_o,
    output logic                                mem_req_o,
    output logic [AddrWidth-1:0]                mem_addr_o,
    output logic [DataWidth-1:0]                mem_wdata_o,
    output logic [NB_COL-1:0]                   mem_bwe_o,
    input  logic [DataWidth-1:0]                mem_rdata_i
);

    localparam int                   TagWidth = tag_width(NUM_PORTS);
    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(RAM_DEPTH - 1);

    ctrl_state_e           state_q;
    logic [AddrWidth-1:0]  clr_cnt_q;
    logic                  rsp_valid_q;
    logic [TagWidth-1:0]   rsp_id_q;
    logic [NUM_PORTS-1:0]  arb_gnt;
    logic [TagWidth-1:0]   arb_idx;
    logic                  serving;
    logic                  any_gnt;

    // Reset masks everything combinationally, so a held reset never leaks a grant.
    assign serving      = (state_q == SERVE) && !rst_i;
    assign any_gnt      = serving && (|req_i);
    assign clear_done_o = serving;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req     (req_i),
        .advance (any_gnt),
        .gnt     (arb_gnt),
        .idx     (arb_idx)
    );

    // Sequencer: walk the clear counter through every word, then serve.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= CLEAR_ON_RESET ? CLEAR : SERVE;
            clr_cnt_q <= '0;
        end else if (state_q == CLEAR) begin
            if (clr_cnt_q == LastAddr) begin
                state_q   <= SERVE;
                clr_cnt_q <= '0;
            end else begin
                clr_cnt_q <= clr_cnt_q + 1'b1;
            end
        end
    end

    // Remember who was granted so the next-cycle RAM data goes back to them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            rsp_valid_q <= any_gnt;
            if (any_gnt) begin
                rsp_id_q <= arb_idx;
            end
        end
    end

    // RAM port mux: clear writer during CLEAR, arbitration winner during SERVE.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_bwe_o   = '0;
        gnt_o       = '0;
        if (!rst_i) begin
            if (state_q == CLEAR) begin
                mem_req_o  = 1'b1;
                mem_addr_o = clr_cnt_q;
                mem_bwe_o  = '1;
            end else if (any_gnt) begin
                mem_req_o   = 1'b1;
                gnt_o       = arb_gnt;
                mem_addr_o  = addr_i[arb_idx];
                mem_wdata_o = wdata_i[arb_idx];
                mem_bwe_o   = bwe_i[arb_idx];
            end
        end
    end

    // Response demux: data is steered to the tagged port, zero elsewhere.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        if (!rst_i && rsp_valid_q) begin
            rvalid_o[rsp_id_q] = 1'b1;
            rdata_o[rsp_id_q]  = mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_sp_bram_ctrl.sv
// Scoreboard bench for sp_bram_ctrl with a small byte-writable RAM model.
module tb_sp_bram_ctrl;

    localparam int NP    = 2;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 32;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                   rst_i;
    logic [NP-1:0]          req_i;
    logic [NP-1:0][AW-1:0]  addr_i;
    logic [NP-1:0][DW-1:0]  wdata_i;
    logic [NP-1:0][3:0]     bwe_i;
    logic [NP-1:0]          gnt_o;
    logic [NP-1:0]          rvalid_o;
    logic [NP-1:0][DW-1:0]  rdata_o;
    logic                   clear_done_o;
    logic                   mem_req_o;
    logic [AW-1:0]          mem_addr_o;
    logic [DW-1:0]          mem_wdata_o;
    logic [3:0]             mem_bwe_o;
    logic [DW-1:0]          mem_rdata_i;

    logic                   rst2;
    logic [NP-1:0]          req2;
    logic [NP-1:0]          gnt2;
    logic [NP-1:0]          rvalid2;
    logic [NP-1:0][DW-1:0]  rdata2;
    logic                   clear_done2;
    logic                   mem_req2;
    logic [AW-1:0]          mem_addr2;
    logic [DW-1:0]          mem_wdata2;
    logic [3:0]             mem_bwe2;
    logic [DW-1:0]          mem_rdata2;
    assign mem_rdata2 = 32'hC0FF_EE11;

    sp_bram_ctrl #(
        .NUM_PORTS(NP), .NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .bwe_i(bwe_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .clear_done_o(clear_done_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_bwe_o(mem_bwe_o), .mem_rdata_i(mem_rdata_i)
    );

    sp_bram_ctrl #(
        .NUM_PORTS(NP), .NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(DEPTH), .CLEAR_ON_RESET(1'b0)
    ) dut_nc (
        .clk_i(clk_i), .rst_i(rst2), .req_i(req2), .addr_i(addr_i), .wdata_i(wdata_i),
        .bwe_i(bwe_i), .gnt_o(gnt2), .rvalid_o(rvalid2), .rdata_o(rdata2),
        .clear_done_o(clear_done2), .mem_req_o(mem_req2), .mem_addr_o(mem_addr2),
        .mem_wdata_o(mem_wdata2), .mem_bwe_o(mem_bwe2), .mem_rdata_i(mem_rdata2)
    );

    // RAM model: registered read-first output, byte-lane writes.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk_i) begin
        if (mem_req_o) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_bwe_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end
            mem_rdata_i <= ram[mem_addr_o];
        end
    end

    typedef struct {
        int            port;
        logic          wr;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          sbq[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            prio_m;
    bit            serving_m;
    int            last_win;
    int            n_chk;
    int            n_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One serve cycle: check the pending response and this cycle's grant.
    task automatic tick();
        rsp_t e;
        int   win;
        @(negedge clk_i);
        chk("clear_done", 64'(clear_done_o), 64'(serving_m));
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("rvalid", 64'(rvalid_o), 64'(1) << e.port);
            if (!e.wr) chk("rdata", 64'(rdata_o), 64'(e.data) << (32 * e.port));
        end else begin
            chk("rvalid_idle", 64'(rvalid_o), 64'(0));
            chk("rdata_idle", 64'(rdata_o), 64'(0));
        end
        win = -1;
        if (serving_m) begin
            for (int i = 0; i < NP; i++) begin
                int p;
                p = (prio_m + i) % NP;
                if (win < 0 && req_i[p]) win = p;
            end
        end
        chk("gnt", 64'(gnt_o), (win < 0) ? 64'(0) : (64'(1) << win));
        chk("mem_req", 64'(mem_req_o), 64'(win >= 0));
        if (win >= 0) begin
            chk("mem_addr", 64'(mem_addr_o), 64'(addr_i[win]));
            chk("mem_bwe", 64'(mem_bwe_o), 64'(bwe_i[win]));
            e.port = win;
            e.wr   = |bwe_i[win];
            e.data = ref_mem[addr_i[win]];
            if (e.wr) begin
                chk("mem_wdata", 64'(mem_wdata_o), 64'(wdata_i[win]));
                for (int b = 0; b < 4; b++) begin
                    if (bwe_i[win][b]) ref_mem[addr_i[win]][8*b +: 8] = wdata_i[win][8*b +: 8];
                end
            end
            sbq.push_back(e);
            prio_m = (win + 1) % NP;
        end
        last_win = win;
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_clear(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_i);
            chk("clr_req", 64'(mem_req_o), 64'(1));
            chk("clr_addr", 64'(mem_addr_o), 64'(k));
            chk("clr_bwe", 64'(mem_bwe_o), 64'(4'hF));
            chk("clr_wdata", 64'(mem_wdata_o), 64'(0));
            chk("clr_done", 64'(clear_done_o), 64'(0));
            chk("clr_gnt", 64'(gnt_o), 64'(0));
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic reset_model();
        sbq.delete();
        prio_m    = 0;
        serving_m = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        req_i[p]   = 1'b1;
        addr_i[p]  = a;
        wdata_i[p] = d;
        bwe_i[p]   = be;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        last_win = -1;
        reset_model();
        rst_i = 1'b1; rst2 = 1'b1;
        req_i = '0; req2 = '0;
        addr_i = '0; wdata_i = '0; bwe_i = '0;

        // Held reset: requests present but every output forced low.
        repeat (3) @(posedge clk_i);
        #1;
        req_i = 2'b11;
        @(negedge clk_i);
        chk("rst_gnt", 64'(gnt_o), 64'(0));
        chk("rst_mem_req", 64'(mem_req_o), 64'(0));
        chk("rst_done", 64'(clear_done_o), 64'(0));
        chk("rst_rvalid", 64'(rvalid_o), 64'(0));
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Partial clear with requests pending, then reset at address 7.
        run_clear(7);
        chk("clr_at7", 64'(mem_addr_o), 64'(7));
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("midclr_mem_req", 64'(mem_req_o), 64'(0));
        chk("midclr_gnt", 64'(gnt_o), 64'(0));
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        req_i = '0;
        run_clear(DEPTH);
        serving_m = 1'b1;

        // First serve cycle: read of a cleared word.
        set_port(0, 4'd5, 32'h0, 4'h0);
        tick();
        req_i = '0;
        tick();

        // Single port: partial byte write then readback.
        set_port(0, 4'd3, 32'hDEAD_BEEF, 4'b0101);
        tick();
        set_port(0, 4'd3, 32'h0, 4'h0);
        tick();
        req_i = '0;
        tick();
        chk("partial_model", 64'(ref_mem[3]), 64'(32'h00AD_00EF));

        // Contention: both write, then both read continuously.
        set_port(0, 4'd8, 32'h1111_2222, 4'hF);
        set_port(1, 4'd9, 32'h3333_4444, 4'hF);
        tick();
        tick();
        set_port(0, 4'd8, 32'h0, 4'h0);
        set_port(1, 4'd9, 32'h0, 4'h0);
        repeat (4) tick();
        req_i = '0;
        tick();

        // Priority pointer: port 1 alone, then both request.
        set_port(1, 4'd9, 32'h0, 4'h0);
        tick();
        set_port(0, 4'd8, 32'h0, 4'h0);
        @(negedge clk_i);
        chk("prio_p0_first", 64'(gnt_o), 64'(2'b01));
        @(posedge clk_i);
        #1;
        // The manual cycle above granted port 0; bring the model in step.
        begin
            rsp_t e;
            e.port = 0; e.wr = 1'b0; e.data = ref_mem[8];
            sbq.pop_front();
            sbq.push_back(e);
            prio_m = 1;
        end
        req_i[0] = 1'b0;
        tick();
        chk("prio_p1_next", 64'(last_win), 64'(1));
        req_i = '0;
        tick();

        // Random traffic honouring hold-until-grant.
        for (int c = 0; c < 60; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (!req_i[p] && $urandom_range(0, 2) != 0) begin
                    set_port(p, AW'($urandom_range(0, DEPTH - 1)), DW'($urandom),
                             ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0);
                end
            end
            tick();
            if (last_win >= 0) req_i[last_win] = 1'b0;
        end
        req_i = '0;
        tick();
        tick();

        // Reset the cycle after a grant: the response must be dropped.
        set_port(0, 4'd3, 32'h0, 4'h0);
        tick();
        rst_i = 1'b1;
        req_i = '0;
        @(negedge clk_i);
        chk("midsrv_rvalid", 64'(rvalid_o), 64'(0));
        chk("midsrv_rdata", 64'(rdata_o), 64'(0));
        chk("midsrv_mem_req", 64'(mem_req_o), 64'(0));
        chk("midsrv_done", 64'(clear_done_o), 64'(0));
        chk("midsrv_gnt", 64'(gnt_o), 64'(0));
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        reset_model();
        run_clear(DEPTH);
        serving_m = 1'b1;
        set_port(0, 4'd3, 32'h0, 4'h0);
        tick();
        req_i = '0;
        tick();

        // No-clear instance: serving and granting in the first cycle after reset.
        addr_i[0] = 4'd6;
        bwe_i[0]  = 4'h0;
        req2      = 2'b01;
        @(negedge clk_i);
        chk("nc_rst_gnt", 64'(gnt2), 64'(0));
        chk("nc_rst_done", 64'(clear_done2), 64'(0));
        @(posedge clk_i);
        #1;
        rst2 = 1'b0;
        @(negedge clk_i);
        chk("nc_done", 64'(clear_done2), 64'(1));
        chk("nc_gnt", 64'(gnt2), 64'(2'b01));
        chk("nc_mem_req", 64'(mem_req2), 64'(1));
        chk("nc_mem_addr", 64'(mem_addr2), 64'(6));
        chk("nc_rvalid0", 64'(rvalid2), 64'(0));
        @(posedge clk_i);
        #1;
        req2 = '0;
        @(negedge clk_i);
        chk("nc_rvalid", 64'(rvalid2), 64'(2'b01));
        chk("nc_rdata", 64'(rdata2), 64'(32'hC0FF_EE11));
        chk("nc_gnt_idle", 64'(gnt2), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sp_bram_ctrl.md
# sp_bram_ctrl

Request arbiter and sequencer in front of one `sp_bram` instance. It shares the single RAM port between `NUM_PORTS` requesters using round-robin arbitration, and routes each one-cycle-latency read response back to the requester that issued it. After reset it can optionally sequence a zero-fill of the whole RAM before accepting traffic. It sits between the core/DMA request ports and the byte-writable block RAM.

## Interface
Parameters:
- `NUM_PORTS`, default 2: number of requesters, ≥2.
- `NB_COL`, default 4: byte lanes per word.
- `COL_WIDTH`, default 8: bits per lane.
- `RAM_DEPTH`, default 1024: words in the RAM.
- `CLEAR_ON_RESET`, default 1: when 1, zero-fill the RAM after reset before serving requests.
- Derived: `DataWidth` = `NB_COL*COL_WIDTH`; `AddrWidth` = `$clog2(RAM_DEPTH)`.

Ports:
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `req_i`, in, `[NUM_PORTS]`: request valid, one bit per port.
- `addr_i`, in, `[NUM_PORTS][AddrWidth]`: word address.
- `wdata_i`, in, `[NUM_PORTS][DataWidth]`: write data.
- `bwe_i`, in, `[NUM_PORTS][NB_COL]`: byte write enables. All-zero means a read.
- `gnt_o`, out, `[NUM_PORTS]`: request accepted this cycle. Combinational.
- `rvalid_o`, out, `[NUM_PORTS]`: response valid, exactly one cycle after grant.
- `rdata_o`, out, `[NUM_PORTS][DataWidth]`: response data. Zero when the matching `rvalid_o` bit is low.
- `clear_done_o`, out, 1: high once the controller is in SERVE.
- `mem_req_o`, out, 1: drives the RAM `req_i`.
- `mem_addr_o`, out, `AddrWidth`: drives the RAM `addr_i`.
- `mem_wdata_o`, out, `DataWidth`: drives the RAM `wdata_i`.
- `mem_bwe_o`, out, `NB_COL`: drives the RAM `bwe_i`.
- `mem_rdata_i`, in, `DataWidth`: the RAM's registered `rdata_o`.

## Operation
- FSM states are CLEAR and SERVE.
- Reset enters CLEAR if `CLEAR_ON_RESET`=1, otherwise SERVE.
- CLEAR behaviour:
  - `clr_cnt_q` runs 0 to `RAM_DEPTH-1`, one word per cycle.
  - Memory outputs: `mem_req_o`=1, `mem_addr_o`=`clr_cnt_q`, `mem_wdata_o`=0, `mem_bwe_o`=all-ones.
  - After the cycle that writes address `RAM_DEPTH-1`, the FSM moves to SERVE.
  - `gnt_o`, `rvalid_o` and `clear_done_o` stay 0 throughout.
- SERVE behaviour:
  - At most one grant per cycle.
  - Winner: the first requesting port at or after `prio_q`, scanning upward cyclically.
  - On a grant, `prio_q` ← (winner+1) mod `NUM_PORTS`. With no request, `prio_q` holds.
  - The winner's addr, wdata and bwe pass combinationally to `mem_*`, with `mem_req_o`=1. With no winner, `mem_req_o`=0.
- Response tracking:
  - On a grant, `rsp_valid_q`←1 and `rsp_id_q`←winner; otherwise `rsp_valid_q`←0.
  - `rvalid_o[rsp_id_q]` = `rsp_valid_q`, and `rdata_o[rsp_id_q]` = `mem_rdata_i`.
- Writes also produce `rvalid_o`, as an acknowledge. `rdata_o` content for a write is don't-care.
- Requesters hold `req_i` and payload stable until `gnt_o`. The controller has no outstanding-request limit beyond one in flight per cycle.

## Timing
- Reset (`rst_i` high at an edge):
  - Registers return to reset values: state, `clr_cnt_q`=0, `prio_q`=0, `rsp_valid_q`=0.
  - In the cycle after the reset edge, `gnt_o`=0, `rvalid_o`=0, `rdata_o`=0. `clear_done_o`=0 if `CLEAR_ON_RESET`, else 1.
  - While `rst_i` is high, all outputs are combinationally forced to 0, including `mem_req_o`.
- Reset mid-CLEAR restarts the fill at address 0. Reset mid-SERVE drops the in-flight response: no `rvalid_o` for it.
- Clear duration is exactly `RAM_DEPTH` cycles; the first grant is possible in cycle `RAM_DEPTH` after reset release.
- Grant latency: same cycle as `req_i`, if the port wins.
- Response latency: 1 cycle after grant.
- Back-to-back grants every cycle are allowed; throughput is 1 access per cycle.
- Simultaneous events:
  - A grant and the previous grant's response occur in the same cycle independently.
  - The same port may be granted in consecutive cycles only if no other port requests.

## Structure
- `sp_bram_ctrl_pkg` holds:
  - the `ctrl_state_e` enum {CLEAR, SERVE};
  - the response-tag width function `$clog2(NUM_PORTS)`.
- Sub-module `rr_arbiter`, parameterised on `NUM_PORTS`:
  - inputs: `req`, `advance`;
  - outputs: one-hot `gnt` and binary `idx`;
  - owns the `prio_q` register.
- `sp_bram_ctrl` contains the FSM, the clear counter, the mux to the memory and response demux. It does not instantiate `sp_bram`.

## Test plan
- Clear: `RAM_DEPTH`=16, `CLEAR_ON_RESET`=1.
  - Stimulus: release reset.
  - Expected: 16 cycles of writes, addresses 0..15, bwe 4'hF, data 0. `clear_done_o` rises in cycle 16. A read of address 5 then returns 0.
- Single port: port 0 writes 32'hDEADBEEF with bwe 4'b0101 to address 3, then reads address 3.
  - Expected: each access gets a grant, then `rvalid_o[0]` the next cycle.
  - Read data is 32'h00AD00EF.
- Contention: both ports request continuously, each to a distinct address.
  - Expected: grants alternate 0, 1, 0, 1.
  - Each `rvalid_o` lands only on the matching port, one cycle later, with correct data.
- Priority pointer: port 1 alone is granted, then both ports request.
  - Expected: port 0 wins next, then port 1.
- Reset mid-operation:
  - Assert `rst_i` during clear at address 7. Expected: the fill restarts at 0.
  - Assert `rst_i` the cycle after a grant. Expected: no `rvalid_o`, all outputs 0.
- `CLEAR_ON_RESET`=0.
  - Expected: `clear_done_o`=1 in the first cycle after reset. A request in that cycle is granted immediately.
